// File: rtl/pp6_driver_if.sv
// Stimulus/response bundle between pp6_driver and whoever controls it.
// The slave modport is the driver's view; master is the controller's view.
interface pp6_driver_if;
    logic        start;
    logic        abort;
    logic [2:0]  len;
    logic [15:0] pat;
    logic        y_in;
    logic        a;
    logic        b;
    logic        valid;
    logic        busy;
    logic        done;
    logic [7:0]  y_cap;

    modport master (
        output start, abort, len, pat, y_in,
        input  a, b, valid, busy, done, y_cap
    );

    modport slave (
        input  start, abort, len, pat, y_in,
        output a, b, valid, busy, done, y_cap
    );
endinterface

// File: rtl/pp6_driver.sv
// Stimulus driver and response capture for a two-input a/b -> y sequence FSM.
// Plays up to 8 packed (a,b) pairs, one per clock, and records the FSM's
// registered y for each pair into y_cap, then pulses done.
module pp6_driver (
    input logic          clk_i,
    input logic          rst_i,
    pp6_driver_if.slave  bus_io
);

    typedef enum logic [1:0] {StIdle, StDrive, StFlush} state_e;

    state_e      state_q, state_d;
    logic [15:0] pat_q, pat_d;
    logic [2:0]  len_q, len_d;
    logic [3:0]  tx_q, tx_d;
    logic [3:0]  cap_q, cap_d;
    logic        a_q, a_d;
    logic        b_q, b_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  y_cap_q, y_cap_d;
    logic [3:0]  n_pairs;

    assign n_pairs = {1'b0, len_q} + 4'd1;

    // Next-state and registered-output computation; abort overrides everything.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        tx_d    = tx_q;
        cap_d   = cap_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        y_cap_d = y_cap_q;

        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    pat_d   = bus_io.pat;
                    len_d   = bus_io.len;
                    y_cap_d = 8'h00;
                    a_d     = bus_io.pat[1];
                    b_d     = bus_io.pat[0];
                    valid_d = 1'b1;
                    tx_d    = 4'd1;
                    cap_d   = 4'd0;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                if (tx_q < n_pairs) begin
                    a_d  = pat_q[{tx_q[2:0], 1'b1}];
                    b_d  = pat_q[{tx_q[2:0], 1'b0}];
                    tx_d = tx_q + 4'd1;
                end else begin
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    valid_d = 1'b0;
                    state_d = StFlush;
                end
                // The FSM's y for pair i is only registered two edges after
                // the pair appears, so the first DRIVE edge has nothing to take.
                if (tx_q >= 4'd2) begin
                    y_cap_d[cap_q[2:0]] = bus_io.y_in;
                    cap_d               = cap_q + 4'd1;
                end
            end
            StFlush: begin
                y_cap_d[len_q] = bus_io.y_in;
                done_d         = 1'b1;
                state_d        = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (bus_io.abort) begin
            state_d = StIdle;
            a_d     = 1'b0;
            b_d     = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b0;
            y_cap_d = y_cap_q;
            pat_d   = pat_q;
            len_d   = len_q;
            tx_d    = tx_q;
            cap_d   = cap_q;
        end

        busy_d = (state_d != StIdle);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            pat_q   <= 16'h0000;
            len_q   <= 3'd0;
            tx_q    <= 4'd0;
            cap_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_cap_q <= 8'h00;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            tx_q    <= tx_d;
            cap_q   <= cap_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_cap_q <= y_cap_d;
        end
    end

    assign bus_io.a     = a_q;
    assign bus_io.b     = b_q;
    assign bus_io.valid = valid_q;
    assign bus_io.busy  = busy_q;
    assign bus_io.done  = done_q;
    assign bus_io.y_cap = y_cap_q;

endmodule
